dmem_responder: RTL and testbench

- Memory-side responder for the CPU's load/store data port. Services one request at a time using a valid/ready request channel and a valid/ready response channel.
- Supports byte, half-word and word stores, and sign- or zero-extended loads, against an internal little-endian word array.
- Adds a configurable wait-state counter, so the core can be exercised against multi-cycle memory latency before the pipelined datapath is integrated.

---
 rtl/dmem_responder.sv | 164 ++++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder over a little-endian word array, with WAIT_CYCLES of added latency.
// Define DMEM_ERR_EN to flag misaligned half/word accesses instead of forcing them aligned.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_write_mem,
   input  logic [2:0]  req_read_mem,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [1:0]          write_q;
   logic [2:0]          read_q;

   logic [31:0]         mem [DEPTH_WORDS];

   logic [ADDR_W-1:0]   word_idx;
   logic [1:0]          lane;
   logic [31:0]         cur_word;
   logic [31:0]         wr_word;
   logic [31:0]         new_word;
   logic [3:0]          be;
   logic [7:0]          byte_sel;
   logic [15:0]         half_sel;
   logic [31:0]         rdata_nxt;
   logic                misaligned;
   logic                do_access;

   // Upper address bits are intentionally discarded: accesses wrap modulo the array size.
   logic unused_addr;
   assign unused_addr = ^req_addr[31:ADDR_W+2];

   assign word_idx  = addr_q[ADDR_W+1:2];
   assign lane      = addr_q[1:0];
   assign cur_word  = mem[word_idx];
   assign do_access = (state == ACCESS) && (cnt == 4'd0);

   always_comb begin
      misaligned = 1'b0;
`ifdef DMEM_ERR_EN
      if (write_q != 2'b00) begin
         misaligned = ((write_q == 2'b10) && lane[0]) ||
                      ((write_q == 2'b11) && (lane != 2'b00));
      end else begin
         misaligned = (((read_q == 3'b011) || (read_q == 3'b100)) && lane[0]) ||
                      ((read_q == 3'b101) && (lane != 2'b00));
      end
`endif
   end

   always_comb begin
      be      = 4'b0000;
      wr_word = wdata_q;
      case (write_q)
         2'b01: begin
            be      = 4'b0001 << lane;
            wr_word = {4{wdata_q[7:0]}};
         end
         2'b10: begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wdata_q[15:0]}};
         end
         2'b11: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      if (misaligned) be = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         new_word[8*i +: 8] = be[i] ? wr_word[8*i +: 8] : cur_word[8*i +: 8];
      end
   end

   always_comb begin
      case (lane)
         2'd0:    byte_sel = cur_word[7:0];
         2'd1:    byte_sel = cur_word[15:8];
         2'd2:    byte_sel = cur_word[23:16];
         default: byte_sel = cur_word[31:24];
      endcase
      half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
      case (read_q)
         3'b001:  rdata_nxt = {{24{byte_sel[7]}}, byte_sel};
         3'b010:  rdata_nxt = {24'd0, byte_sel};
         3'b011:  rdata_nxt = {{16{half_sel[15]}}, half_sel};
         3'b100:  rdata_nxt = {16'd0, half_sel};
         3'b101:  rdata_nxt = cur_word;
         default: rdata_nxt = 32'd0;
      endcase
      // A store wins over a simultaneous load code.
      if ((write_q != 2'b00) || misaligned) rdata_nxt = 32'd0;
   end

   // Gated by rst so a reset on the commit edge drops the write.
   always_ff @(posedge clk) begin
      if (rst && do_access && (be != 4'b0000)) begin
         mem[word_idx] <= new_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         write_q    <= 2'b00;
         read_q     <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q    <= req_addr[ADDR_W+1:0];
                  wdata_q   <= req_wdata;
                  write_q   <= req_write_mem;
                  read_q    <= req_read_mem;
                  cnt       <= 4'(WAIT_CYCLES);
                  req_ready <= 1'b0;
                  state     <= ACCESS;
               end else begin
                  req_ready <= 1'b1;
               end
            end
            ACCESS: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  resp_rdata <= rdata_nxt;
                  resp_err   <= misaligned;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stimulus pushes expected responses, a monitor pops and compares.
module tb_dmem_responder;
   localparam int WAIT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [1:0]  req_write_mem = 2'b00;
   logic [2:0]  req_read_mem = 3'b000;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;

   dmem_responder #(.DEPTH_WORDS(1024), .ADDR_W(10), .WAIT_CYCLES(WAIT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_write_mem(req_write_mem), .req_read_mem(req_read_mem),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;

   exp_t  expq[$];
   int    accq[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   logic  prev_vld = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   // Monitor: acceptance timestamps, first-valid latency, and response scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         accq.delete();
      end else begin
         if (req_valid && req_ready) accq.push_back(cyc + 1);
         if (resp_valid && !prev_vld) begin
            if (accq.size() == 0) fail("latency: response without acceptance");
            else chk("latency", 32'(cyc - accq.pop_front()), 32'(WAIT + 1));
         end
         if (resp_valid && resp_ready) begin
            if (expq.size() == 0) begin
               fail("unexpected response");
            end else begin
               e = expq.pop_front();
               chk({e.name, " rdata"}, resp_rdata, e.rdata);
               chk({e.name, " err"}, {31'd0, resp_err}, {31'd0, e.err});
            end
         end
      end
      prev_vld = resp_valid;
   end

   task automatic drive(input logic [1:0] w, input logic [2:0] r,
                        input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      req_valid = 1'b1; req_write_mem = w; req_read_mem = r;
      req_addr = a; req_wdata = d;
   endtask

   task automatic wait_accept(input logic [31:0] er, input logic ee, input string name);
      exp_t e;
      int   n = 0;
      while (1) begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 100) begin
            fail({name, " accept timeout"});
            req_valid = 1'b0;
            return;
         end
      end
      e.rdata = er; e.err = ee; e.name = name;
      expq.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic issue(input logic [1:0] w, input logic [2:0] r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input string name);
      drive(w, r, a, d);
      wait_accept(er, ee, name);
   endtask

   task automatic drain();
      int n = 0;
      while (expq.size() != 0 || resp_valid) begin
         @(negedge clk);
         n++;
         if (n > 200) begin
            fail("drain timeout");
            expq.delete();
            return;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("reset req_ready", {31'd0, req_ready}, 32'd0);
      chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("reset resp_rdata", resp_rdata, 32'd0);
      chk("reset resp_err", {31'd0, resp_err}, 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      issue(2'b11, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw 0x10");
      issue(2'b00, 3'b101, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw 0x10");

      issue(2'b11, 3'b000, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, "sw 0x20");
      issue(2'b00, 3'b001, 32'h20, 32'h0, 32'h00000001, 1'b0, "lb 0x20");
      issue(2'b00, 3'b001, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, "lb 0x23");
      issue(2'b00, 3'b010, 32'h21, 32'h0, 32'h0000007F, 1'b0, "lbu 0x21");
      issue(2'b00, 3'b011, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, "lh 0x22");
      issue(2'b00, 3'b100, 32'h22, 32'h0, 32'h000080FF, 1'b0, "lhu 0x22");

      issue(2'b11, 3'b101, 32'h50, 32'h0000CAFE, 32'h0, 1'b0, "sw+lw 0x50");
      issue(2'b00, 3'b101, 32'h50, 32'h0, 32'h0000CAFE, 1'b0, "lw 0x50");
      issue(2'b00, 3'b110, 32'h10, 32'h0, 32'h0, 1'b0, "load code 110");
      issue(2'b00, 3'b000, 32'h10, 32'h0, 32'h0, 1'b0, "no-op");

      issue(2'b11, 3'b000, 32'h30, 32'h11223344, 32'h0, 1'b0, "sw 0x30");
      issue(2'b01, 3'b000, 32'h31, 32'h000000AA, 32'h0, 1'b0, "sb 0x31");
      issue(2'b10, 3'b000, 32'h32, 32'h0000BBCC, 32'h0, 1'b0, "sh 0x32");
      issue(2'b00, 3'b101, 32'h30, 32'h0, 32'hBBCCAA44, 1'b0, "lw 0x30");
      drain();

      // Response held off for 5 cycles while another request is offered.
      @(posedge clk); #1 resp_ready = 1'b0;
      issue(2'b00, 3'b101, 32'h20, 32'h0, 32'h80FF7F01, 1'b0, "stalled lw 0x20");
      n = 0;
      while (!resp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!resp_valid) fail("stall: resp_valid never rose");
      drive(2'b00, 3'b101, 32'h30, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall resp_rdata", resp_rdata, 32'h80FF7F01);
         chk("stall req_ready", {31'd0, req_ready}, 32'd0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      wait_accept(32'hBBCCAA44, 1'b0, "lw 0x30 after stall");

      issue(2'b11, 3'b000, 32'h1000, 32'h5, 32'h0, 1'b0, "sw wrap");
      issue(2'b00, 3'b101, 32'h0, 32'h0, 32'h5, 1'b0, "lw 0x0 wrap");

      issue(2'b11, 3'b000, 32'h40, 32'h12345678, 32'h0, 1'b0, "sw 0x40");
      drain();

      // Reset lands in ACCESS: the store must be abandoned.
      drive(2'b11, 3'b000, 32'h40, 32'h9);
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (req_ready) break;
         n++;
      end
      if (!req_ready) fail("abort: request never accepted");
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("abort resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("abort req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      issue(2'b00, 3'b101, 32'h40, 32'h0, 32'h12345678, 1'b0, "lw 0x40 after abort");

`ifdef DMEM_ERR_EN
      issue(2'b10, 3'b000, 32'h41, 32'h0000BBCC, 32'h0, 1'b1, "sh 0x41 misaligned");
      issue(2'b00, 3'b101, 32'h40, 32'h0, 32'h12345678, 1'b0, "lw 0x40 after sh");
`else
      issue(2'b10, 3'b000, 32'h41, 32'h0000BBCC, 32'h0, 1'b0, "sh 0x41 aligned");
      issue(2'b00, 3'b101, 32'h40, 32'h0, 32'h1234BBCC, 1'b0, "lw 0x40 after sh");
`endif
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
